// File: rtl/lsu_data_memory.sv
// Multi-cycle load/store unit with a word-organised data memory.
// Request-to-done latency is WAIT_CYCLES+1; stall is high from the request cycle until done.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses are trapped instead of force-aligned.
module lsu_data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_f3;
  logic        lat_wr;
  logic        mis_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req;
  logic        accept;
  logic        exec;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic [2:0]  x_f3;
  logic        x_wr;
  logic        legal;
  logic        trap;
  logic [1:0]  lane;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] rword;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ldata;
  logic        do_write;
  logic        unused_addr_bits;

  assign req    = memRead | memWrite;
  assign accept = (state == S_IDLE) && req;
  assign stall  = reset && ((state == S_WAIT) || accept);

  // With zero wait states the access executes on the accept edge, so it must use the live inputs.
  assign exec    = (WAIT_CYCLES == 0) ? accept : ((state == S_WAIT) && (cnt == 4'd0));
  assign x_addr  = (WAIT_CYCLES == 0) ? address   : lat_addr;
  assign x_wdata = (WAIT_CYCLES == 0) ? writeData : lat_wdata;
  assign x_f3    = (WAIT_CYCLES == 0) ? funct3    : lat_f3;
  assign x_wr    = (WAIT_CYCLES == 0) ? memWrite  : lat_wr;

  assign legal = (x_f3 == 3'b000) || (x_f3 == 3'b001) || (x_f3 == 3'b010) ||
                 (x_f3 == 3'b100) || (x_f3 == 3'b101);

  // Address decode: trap on misalignment, or force natural alignment when trapping is off.
  always_comb begin
    lane = x_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    trap = legal && (((x_f3[1:0] == 2'b01) && x_addr[0]) ||
                     ((x_f3[1:0] == 2'b10) && (x_addr[1:0] != 2'b00)));
`else
    trap = 1'b0;
    if (x_f3[1:0] == 2'b01) lane[0] = 1'b0;
    else if (x_f3[1:0] == 2'b10) lane = 2'b00;
`endif
  end

  assign idx = x_addr[AW+1:2];
  assign unused_addr_bits = ^{x_addr[31:AW+2]};

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    be    = 4'b1111;
    wword = x_wdata;
    case (x_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{x_wdata[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{x_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = x_wdata;
      end
    endcase
  end

  // Load extraction with sign/zero extension.
  always_comb begin
    rword = mem[idx];
    bsel  = 8'(rword >> {lane, 3'b000});
    hsel  = lane[1] ? rword[31:16] : rword[15:0];
    case (x_f3[1:0])
      2'b00:   ldata = x_f3[2] ? {24'd0, bsel} : {{24{bsel[7]}}, bsel};
      2'b01:   ldata = x_f3[2] ? {16'd0, hsel} : {{16{hsel[15]}}, hsel};
      default: ldata = rword;
    endcase
  end

  // A store only commits on its execute edge and never while reset is asserted.
  assign do_write = exec && x_wr && legal && !trap && reset;

  // Memory array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Control FSM with registered result, done and misaligned pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_f3    <= 3'd0;
      lat_wr    <= 1'b0;
      readData  <= 32'd0;
      done      <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      done  <= 1'b0;
      mis_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_addr  <= address;
            lat_wdata <= writeData;
            lat_f3    <= funct3;
            lat_wr    <= memWrite;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else cnt <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
      if (exec) begin
        done  <= 1'b1;
        mis_q <= trap;
        if (!legal || trap) readData <= 32'd0;
        else if (!x_wr) readData <= ldata;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = mis_q;
`else
  assign misaligned = 1'b0;
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_lsu_data_memory.sv
module tb_lsu_data_memory;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance with two wait states
  logic        rd_w, wr_w;
  logic [2:0]  f3_w;
  logic [31:0] addr_w, wd_w, rdata_w;
  logic        stall_w, done_w, mis_w;
  // Instance with zero wait states
  logic        rd_z, wr_z;
  logic [2:0]  f3_z;
  logic [31:0] addr_z, wd_z, rdata_z;
  logic        stall_z, done_z, mis_z;

  lsu_data_memory #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .memRead(rd_w), .memWrite(wr_w), .funct3(f3_w),
    .address(addr_w), .writeData(wd_w), .readData(rdata_w), .stall(stall_w),
    .done(done_w), .misaligned(mis_w)
  );

  lsu_data_memory #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .memRead(rd_z), .memWrite(wr_z), .funct3(f3_z),
    .address(addr_z), .writeData(wd_z), .readData(rdata_z), .stall(stall_z),
    .done(done_z), .misaligned(mis_z)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic em);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rd = er; v.exp_mis = em;
    vecs.push_back(v);
  endtask

  function automatic logic pick_stall(input bit sel);
    return sel ? stall_z : stall_w;
  endfunction

  // One complete access on the selected instance, checking stall length, done, result and flag.
  task automatic access(input bit sel, input string name, input vec_t v);
    int n;
    logic        dn, ms;
    logic [31:0] rdv;
    @(negedge clk);
    if (sel) begin rd_z = v.rd; wr_z = v.wr; f3_z = v.f3; addr_z = v.addr; wd_z = v.wdata; end
    else     begin rd_w = v.rd; wr_w = v.wr; f3_w = v.f3; addr_w = v.addr; wd_w = v.wdata; end
    #1;
    n = 0;
    while (pick_stall(sel) && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    dn  = sel ? done_z  : done_w;
    ms  = sel ? mis_z   : mis_w;
    rdv = sel ? rdata_z : rdata_w;
    chk({name, "_stall_cycles"}, 32'(n), sel ? 32'd1 : 32'd3);
    chk({name, "_done"}, {31'd0, dn}, 32'd1);
    chk({name, "_readData"}, rdv, v.exp_rd);
    chk({name, "_misaligned"}, {31'd0, ms}, {31'd0, v.exp_mis});
    if (sel) begin rd_z = 1'b0; wr_z = 1'b0; end
    else     begin rd_w = 1'b0; wr_w = 1'b0; end
    @(negedge clk);
    #1;
    dn = sel ? done_z : done_w;
    chk({name, "_done_one_cycle"}, {31'd0, dn}, 32'd0);
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    rd_w = 0; wr_w = 0; f3_w = 0; addr_w = 0; wd_w = 0;
    rd_z = 0; wr_z = 0; f3_z = 0; addr_z = 0; wd_z = 0;

    //  rd  wr  f3      addr       wdata         expected readData                 mis
    add(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000,                          0);
    add(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF,                          0);
    add(0, 1, 3'b000, 32'h13,  32'h00000080, 32'hDEADBEEF,                          0);
    add(1, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80,                          0);
    add(1, 0, 3'b100, 32'h13,  32'h0,        32'h00000080,                          0);
    add(1, 0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF,                          0);
    add(1, 0, 3'b001, 32'h12,  32'h0,        32'hFFFF80AD,                          0);
    add(1, 0, 3'b101, 32'h12,  32'h0,        32'h000080AD,                          0);
    add(0, 1, 3'b001, 32'h10,  32'hFFFF1234, 32'h000080AD,                          0);
    add(1, 0, 3'b010, 32'h10,  32'h0,        32'h80AD1234,                          0);
    add(1, 0, 3'b001, 32'h10,  32'h0,        32'h00001234,                          0);
    add(0, 1, 3'b010, 32'h400, 32'hA5A5A5A5, 32'h00001234,                          0);
    add(1, 0, 3'b010, 32'h000, 32'h0,        32'hA5A5A5A5,                          0);
    add(1, 0, 3'b011, 32'h000, 32'h0,        32'h00000000,                          0);
    add(1, 0, 3'b010, 32'h11,  32'h0,        TRAP ? 32'h0 : 32'h80AD1234,           TRAP);
    add(0, 1, 3'b001, 32'h13,  32'h0000BEEF, TRAP ? 32'h0 : 32'h80AD1234,           TRAP);
    add(1, 0, 3'b010, 32'h10,  32'h0,        TRAP ? 32'h80AD1234 : 32'hBEEF1234,    0);
    add(1, 0, 3'b000, 32'h11,  32'h0,        32'h00000012,                          0);
    add(1, 0, 3'b100, 32'h12,  32'h0,        TRAP ? 32'h000000AD : 32'h000000EF,    0);
    add(1, 1, 3'b010, 32'h20,  32'h0BADF00D, TRAP ? 32'h000000AD : 32'h000000EF,    0);
    add(1, 0, 3'b010, 32'h20,  32'h0,        32'h0BADF00D,                          0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_readData", rdata_w, 32'h0);
    chk("reset_stall", {31'd0, stall_w}, 32'd0);
    chk("reset_done", {31'd0, done_w}, 32'd0);
    chk("reset_misaligned", {31'd0, mis_w}, 32'd0);
    chk("reset0_readData", rdata_z, 32'h0);

    foreach (vecs[i]) access(1'b0, $sformatf("v%0d", i), vecs[i]);

    // Reset in the middle of a store's wait states: the store must be dropped.
    @(negedge clk);
    rd_w = 0; wr_w = 1; f3_w = 3'b010; addr_w = 32'h20; wd_w = 32'h12345678;
    @(negedge clk);
    wr_w = 0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("midwait_reset_readData", rdata_w, 32'h0);
    chk("midwait_reset_stall", {31'd0, stall_w}, 32'd0);
    chk("midwait_reset_done", {31'd0, done_w}, 32'd0);
    reset = 1'b1;
    v = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D, 1'b0};
    access(1'b0, "after_reset_lw", v);

    // Zero wait states: one stall cycle, and read+write together is a store.
    v = '{1'b1, 1'b1, 3'b010, 32'h8, 32'h11223344, 32'h00000000, 1'b0};
    access(1'b1, "z_sw_both", v);
    v = '{1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 32'h11223344, 1'b0};
    access(1'b1, "z_lw", v);
    v = '{1'b1, 1'b0, 3'b000, 32'hB, 32'h0, 32'h00000011, 1'b0};
    access(1'b1, "z_lb", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/lsu_data_memory.md
Name: lsu_data_memory

Overview:
- Multi-cycle load/store unit with integrated word-organised data memory for the RISC-V datapath.
- Sits directly downstream of the ALU: consumes aluResult as the address, readData2 as store data, and memRead/memWrite/funct3 from control.
- Returns readData to the writeback mux.
- Raises stall so the PC holds while an access is in flight.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words. Must be a power of 2.
- WAIT_CYCLES, 2, wait states between accept and completion. Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- memRead  input  1  load request.
- memWrite  input  1  store request. Takes priority over memRead when both are high.
- funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- address  input  32  byte address (aluResult).
- writeData  input  32  store data (readData2). Low bytes are used for sb/sh.
- readData  output  32  load result, sign- or zero-extended.
- stall  output  1  high while a request is pending; PC and pipeline inputs must hold.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  one-cycle pulse with done on a misaligned access.

Behaviour:
- Word index is address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS*4.
- Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request is memRead|memWrite.
  - On a request, stall is combinationally high in the same cycle.
  - The block latches address, funct3, writeData and the op.
  - It then goes to WAIT, loading counter=WAIT_CYCLES-1; if WAIT_CYCLES=0 it goes straight to RESP.
- WAIT:
  - stall=1; counter decrements each cycle.
  - At counter==0 the FSM goes to RESP.
  - Stores commit to memory on this transition edge.
  - The load word is read on this edge.
- RESP:
  - done=1, stall=0 for exactly one cycle, then IDLE.
  - Inputs present during RESP are never accepted; the PC advances at this edge.
- Latency: request-to-done is WAIT_CYCLES+1 cycles, i.e. stall is high for WAIT_CYCLES+1 cycles.
- Store byte lanes:
  - sb writes lane address[1:0] with writeData[7:0].
  - sh writes lanes {address[1],0} and +1 with writeData[15:0].
  - sw writes all lanes.
  - Unselected bytes are preserved.
- Loads:
  - Select the byte or halfword by address bits.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw is passed through.
  - readData updates at the RESP entry edge and holds until the next load completes.
  - Stores leave readData unchanged.
- Illegal funct3 (011, 110, 111): no memory write, readData<=0, done still pulses, misaligned=0.
- Misaligned condition:
  - h/hu/sh when address[0]=1.
  - w/sw when address[1:0]!=0.
  - Handling is defined under Optional Feature.
- Reset low, at any time including mid-WAIT:
  - FSM goes to IDLE; readData=0, stall=0, done=0, misaligned=0.
  - A pending store is dropped and not committed unless its commit edge has already passed.
- Reset values: readData=0, stall=0, done=0, misaligned=0, counter=0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access performs no memory write.
  - It returns readData=0 and pulses misaligned together with done.
  - Latency is unchanged.
- Undefined:
  - The misaligned port is tied to 0.
  - Address low bits are forced to natural alignment: halfword clears bit0, word clears bits[1:0].
  - The access then proceeds normally.

Test Plan:
- WAIT_CYCLES=2, sw 0xDEADBEEF @0x10, then lw @0x10:
  - Each access holds stall high 3 cycles, then pulses done for 1 cycle.
  - lw readData=0xDEADBEEF.
- sb 0x80 @0x13, then read back:
  - lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080.
  - lw @0x10 -> 0x80ADBEEF.
  - lh @0x12 -> 0xFFFF80AD; lhu @0x12 -> 0x000080AD.
- WAIT_CYCLES=0: lw has stall high 1 cycle, done on the next cycle. memRead=memWrite=1 performs a store.
- Reset during WAIT:
  - Drive reset low during WAIT of sw 0x12345678 @0x20.
  - FSM returns to IDLE; a subsequent lw @0x20 returns the prior value.
  - readData=0 immediately after reset.
- DEPTH_WORDS=256, aliasing: sw 0xA5A5A5A5 @0x400, then lw @0x000 -> 0xA5A5A5A5. lw with funct3=011 -> readData 0, done pulses.
- Misaligned lw @0x11:
  - With LSU_MISALIGN_TRAP_EN: misaligned=1 with done, readData=0.
  - Without: returns the word at 0x10, misaligned=0.
